mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the core's instruction-fetch requester and its load/store requester. Each requester holds a request until the arbiter returns a one-cycle completion pulse. The arbiter grants one transaction at a time, drives the memory port, and waits for a variable-latency acknowledge. It also converts memory errors and timeouts into per-requester exception flags, which feed the exception unit's IBE/DBE inputs.

## Interface
- ADDR_W, 30, word-address width (byte address bits [31:2])
- DATA_W, 32, data width
- MAX_WAIT, 15, cycles in BUSY without m_ack/m_err before the transaction aborts (1..255)
- clk  in  1  clock, rising-edge
- rst_b  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held with i_addr stable until i_done
- i_addr  in  ADDR_W  fetch word address
- i_rdata  out  DATA_W  fetched word, valid when i_done=1
- i_done  out  1  one-cycle completion pulse for fetch
- i_excpt  out  1  fetch failed (m_err or timeout), valid with i_done
- d_req  in  1  data request; held with d_addr/d_wdata/d_we stable until d_done
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_we  in  4  byte write mask; 4'b0000 = load
- d_rdata  out  DATA_W  load data, valid when d_done=1
- d_done  out  1  one-cycle completion pulse for data
- d_excpt  out  1  data access failed, valid with d_done
- m_req  out  1  memory request, held until m_ack or m_err or abort
- m_addr  out  ADDR_W  memory word address
- m_wdata  out  DATA_W  memory write data
- m_we  out  4  memory byte write mask
- m_ack  in  1  memory completed; m_rdata valid this cycle
- m_err  in  1  memory error; terminates the transaction
- m_rdata  in  DATA_W  memory read data
- busy  out  1  arbiter state is not IDLE

## Operation
- FSM states: IDLE, BUSY, RESP. The granted requester is held in grant ∈ {G_INST, G_DATA}.
- IDLE: sample i_req/d_req.
  - Only one is asserted: grant it.
  - Both are asserted: grant the requester opposite last_grant (round-robin).
  - Latch the address, write data and mask into the m_* registers, and go to BUSY. last_grant is updated on every grant.
- Fetch grant: m_we=4'b0000 and m_wdata=0.
- Data grant: m_we=d_we and m_wdata=d_wdata.
- BUSY: m_req=1. The timeout counter increments each BUSY cycle.
  - m_ack=1 and m_err=0: capture m_rdata into the granted rdata output, set excpt=0, go to RESP.
  - m_err=1 (with or without m_ack): set rdata=0 and excpt=1, go to RESP.
  - Counter reaches MAX_WAIT with no m_ack/m_err: abort. Set rdata=0 and excpt=1, go to RESP. m_req drops on that edge.
- RESP: pulse done for the granted requester only; m_req=0; requests are ignored. Always go to IDLE next cycle.
- Requester obligation: deassert req, or present a new request, in the cycle after done. A req sampled high in IDLE is a new transaction.
- rdata and excpt hold their value until the next completion for the same port.
- Non-granted port: done=0; its rdata and excpt are unchanged.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Minimum latency: req sampled at edge 0 (IDLE) → m_req=1 in cycle 1. If m_ack=1 in cycle 1, done=1 in cycle 2 and IDLE in cycle 3. So 2 cycles from request to done, 3 cycles per transaction.
- Memory wait: each cycle of m_ack delay adds one cycle.
- Timeout: done with excpt=1 arrives MAX_WAIT+1 cycles after m_req rises.
- m_ack and timeout in the same cycle: m_ack wins and the transaction completes normally.
- Back-to-back ties alternate between the ports: D, I, D, I, …
- Reset values:
  - state IDLE; last_grant G_INST, so the first tie grants data.
  - m_req 0, m_addr 0, m_wdata 0, m_we 0.
  - i_done, d_done, i_excpt, d_excpt 0; i_rdata, d_rdata 0; busy 0.
  - Timeout counter 0.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously). No done is produced, and the in-flight memory access is abandoned.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY, RESP}
  - typedef enum grant_t {G_INST, G_DATA}
  - constant WE_NONE=4'b0000
- Sub-module arb_timeout_ctr (parameter MAX_WAIT): clear, enable, expired output, width $clog2(MAX_WAIT+1). Cleared on entry to BUSY.
- Top level contains the FSM, the round-robin grant logic, the m_* registers and the per-port response registers.

## Test plan
- Lone fetch: i_req=1, i_addr=30'h00100000, m_ack in the first BUSY cycle with m_rdata=32'h24020005 → m_addr=30'h00100000 and m_we=0 in cycle 1; i_done=1, i_rdata=32'h24020005, i_excpt=0 in cycle 2; d_done=0 throughout.
- Store with wait: d_req=1, d_addr=30'h04000000, d_wdata=32'hDEADBEEF, d_we=4'b0011, m_ack after 3 wait cycles → m_we=4'b0011 and m_wdata=32'hDEADBEEF held for all 4 BUSY cycles; d_done in cycle 5.
- Tie after reset: i_req=d_req=1 held continuously with immediate m_ack → grants D, I, D, I. Dones occur at cycles 2, 5, 8, 11.
- Error and timeout:
  - m_err=1 on a load → d_done=1, d_excpt=1, d_rdata=0.
  - No m_ack with MAX_WAIT=15 → i_done and i_excpt at cycle 17; m_req low from cycle 17.
- Reset mid-BUSY: deassert rst_b in the second BUSY cycle → m_req and busy go to 0 without a clock edge; no done pulse. After release, a tie grants data first.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned WE_W = 4;
    localparam logic [WE_W-1:0] WE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        G_INST = 1'b0,
        G_DATA = 1'b1
    } grant_t;

    // Pick the requester to serve; ties go to the port that was not served last.
    function automatic grant_t rr_pick(input logic inst_req, input logic data_req,
                                       input grant_t last);
        if (inst_req && data_req) begin
            return (last == G_INST) ? G_DATA : G_INST;
        end else if (data_req) begin
            return G_DATA;
        end else begin
            return G_INST;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// BUSY-cycle counter that flags when a memory access has waited MAX_WAIT cycles.
module arb_timeout_ctr #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Next count: clear wins, otherwise count up and saturate at MAX_WAIT.
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (enable && (count != CNT_W'(MAX_WAIT))) begin
            count_nxt = count + CNT_W'(1);
        end
    end

    // Count register and registered expiry flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == CNT_W'(MAX_WAIT));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_excpt,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_we,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_excpt,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_we,
    input  logic              m_ack,
    input  logic              m_err,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    arb_state_t        state_q, state_nxt;
    grant_t            grant_q, grant_nxt;
    grant_t            last_grant_q, last_grant_nxt;
    grant_t            pick;

    logic              m_req_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_wdata_nxt;
    logic [3:0]        m_we_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
    logic              i_done_nxt, d_done_nxt;
    logic              i_excpt_nxt, d_excpt_nxt;
    logic              busy_nxt;
    logic              resp_ok;
    logic              ctr_clear;
    logic              ctr_enable;
    logic              tmo_expired;

    arb_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk     (clk),
        .rst_b   (rst_b),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, grant selection, memory command and per-port response values.
    always_comb begin
        state_nxt      = state_q;
        grant_nxt      = grant_q;
        last_grant_nxt = last_grant_q;
        pick           = rr_pick(i_req, d_req, last_grant_q);
        m_req_nxt      = m_req;
        m_addr_nxt     = m_addr;
        m_wdata_nxt    = m_wdata;
        m_we_nxt       = m_we;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        i_excpt_nxt    = i_excpt;
        d_excpt_nxt    = d_excpt;
        i_done_nxt     = 1'b0;
        d_done_nxt     = 1'b0;
        resp_ok        = 1'b0;
        ctr_clear      = 1'b0;
        ctr_enable     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt      = BUSY;
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    m_req_nxt      = 1'b1;
                    ctr_clear      = 1'b1;
                    if (pick == G_DATA) begin
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                        m_we_nxt    = d_we;
                    end else begin
                        m_addr_nxt  = i_addr;
                        m_wdata_nxt = '0;
                        m_we_nxt    = WE_NONE;
                    end
                end
            end
            BUSY: begin
                ctr_enable = 1'b1;
                if (m_ack || m_err || tmo_expired) begin
                    state_nxt = RESP;
                    m_req_nxt = 1'b0;
                    resp_ok   = m_ack && !m_err;
                    if (grant_q == G_DATA) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = resp_ok ? m_rdata : '0;
                        d_excpt_nxt = !resp_ok;
                    end else begin
                        i_done_nxt  = 1'b1;
                        i_rdata_nxt = resp_ok ? m_rdata : '0;
                        i_excpt_nxt = !resp_ok;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                m_req_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Registered grant bookkeeping, memory port and response outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            grant_q      <= G_INST;
            last_grant_q <= G_INST;
            m_req        <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_we         <= WE_NONE;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            i_excpt      <= 1'b0;
            d_excpt      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            grant_q      <= grant_nxt;
            last_grant_q <= last_grant_nxt;
            m_req        <= m_req_nxt;
            m_addr       <= m_addr_nxt;
            m_wdata      <= m_wdata_nxt;
            m_we         <= m_we_nxt;
            i_rdata      <= i_rdata_nxt;
            d_rdata      <= d_rdata_nxt;
            i_done       <= i_done_nxt;
            d_done       <= d_done_nxt;
            i_excpt      <= i_excpt_nxt;
            d_excpt      <= d_excpt_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_excpt;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_we;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_excpt;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_we;
    logic              m_ack;
    logic              m_err;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending requests, who was served last, and each port's last result.
    bit          pend_i;
    bit          pend_d;
    bit          last_data;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    bit          exp_i_excpt;
    bit          exp_d_excpt;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_done  (i_done),
        .i_excpt (i_excpt),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_we    (d_we),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .d_excpt (d_excpt),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ports();
        check("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
        check("i_excpt", 64'(i_excpt), 64'(exp_i_excpt));
        check("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
        check("d_excpt", 64'(d_excpt), 64'(exp_d_excpt));
    endtask

    task automatic model_reset();
        last_data   = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_i_excpt = 1'b0;
        exp_d_excpt = 1'b0;
    endtask

    task automatic new_inst(input logic [ADDR_W-1:0] a);
        i_addr = a;
        i_req  = 1'b1;
        pend_i = 1'b1;
    endtask

    task automatic new_data(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                            input logic [3:0] we);
        d_addr  = a;
        d_wdata = wd;
        d_we    = we;
        d_req   = 1'b1;
        pend_d  = 1'b1;
    endtask

    // One transaction, entered at the falling edge of the IDLE cycle that samples the
    // requests. w = memory wait cycles before the response; w > MAX_WAIT means no response.
    task automatic run_txn(input int w, input bit use_err, input logic [31:0] rd);
        bit          win_d;
        bit          tmo;
        bit          exc;
        int          n;
        logic [29:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ewe;
        logic [31:0] word;
        if (pend_i && pend_d) win_d = !last_data;
        else win_d = pend_d;
        last_data = win_d;
        ea  = win_d ? d_addr : i_addr;
        ewd = win_d ? d_wdata : 32'h0;
        ewe = win_d ? d_we : 4'h0;
        tmo = (w > int'(MAX_WAIT));
        n   = tmo ? int'(MAX_WAIT) + 1 : w + 1;
        word = 32'h0;
        @(negedge clk);
        for (int c = 1; c <= n; c++) begin
            check("busy_m_req", 64'(m_req), 64'(1'b1));
            check("busy_flag", 64'(busy), 64'(1'b1));
            check("busy_i_done", 64'(i_done), 64'(1'b0));
            check("busy_d_done", 64'(d_done), 64'(1'b0));
            check("m_addr", 64'(m_addr), 64'(ea));
            check("m_wdata", 64'(m_wdata), 64'(ewd));
            check("m_we", 64'(m_we), 64'(ewe));
            if (!tmo && c == w + 1) begin
                m_rdata = rd;
                if (use_err) begin
                    m_err = 1'b1;
                    m_ack = 1'($urandom);
                end else begin
                    m_ack = 1'b1;
                    m_err = 1'b0;
                    word  = rd;
                end
            end else begin
                m_rdata = $urandom;
                m_ack   = 1'b0;
                m_err   = 1'b0;
            end
            @(negedge clk);
        end
        m_ack = 1'b0;
        m_err = 1'b0;
        exc = tmo || use_err;
        if (win_d) begin
            exp_d_rdata = exc ? 32'h0 : word;
            exp_d_excpt = exc;
        end else begin
            exp_i_rdata = exc ? 32'h0 : word;
            exp_i_excpt = exc;
        end
        check("resp_i_done", 64'(i_done), 64'(!win_d));
        check("resp_d_done", 64'(d_done), 64'(win_d));
        check("resp_m_req", 64'(m_req), 64'(1'b0));
        check("resp_busy", 64'(busy), 64'(1'b1));
        check_ports();
        if (win_d) begin
            d_req  = 1'b0;
            pend_d = 1'b0;
        end else begin
            i_req  = 1'b0;
            pend_i = 1'b0;
        end
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(1'b0));
        check("idle_m_req", 64'(m_req), 64'(1'b0));
        check("idle_i_done", 64'(i_done), 64'(1'b0));
        check("idle_d_done", 64'(d_done), 64'(1'b0));
        check_ports();
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_m_req"}, 64'(m_req), 64'(1'b0));
        check({tag, "_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_m_addr"}, 64'(m_addr), 64'(0));
        check({tag, "_m_wdata"}, 64'(m_wdata), 64'(0));
        check({tag, "_m_we"}, 64'(m_we), 64'(0));
        check({tag, "_i_done"}, 64'(i_done), 64'(1'b0));
        check({tag, "_d_done"}, 64'(d_done), 64'(1'b0));
        check_ports();
    endtask

    initial begin
        int w;
        int sel;
        bit err;
        rst_b   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_we    = '0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_rdata = '0;
        pend_i  = 1'b0;
        pend_d  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_clear("reset");
        rst_b = 1'b1;

        // Lone fetch with immediate acknowledge.
        new_inst(30'h00100000);
        run_txn(0, 1'b0, 32'h24020005);

        // Store with three wait cycles.
        new_data(30'h04000000, 32'hDEADBEEF, 4'b0011);
        run_txn(3, 1'b0, $urandom);

        // Fresh reset, then continuous ties must alternate D, I, D, I.
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        new_inst(30'h00000100);
        new_data(30'h00000200, 32'h11112222, 4'b1111);
        run_txn(0, 1'b0, $urandom);
        new_data(30'h00000204, 32'h33334444, 4'b0000);
        run_txn(0, 1'b0, $urandom);
        new_inst(30'h00000104);
        run_txn(0, 1'b0, $urandom);
        run_txn(0, 1'b0, $urandom);

        // Load terminated by a memory error.
        new_data(30'h00000300, 32'h0, 4'b0000);
        run_txn(1, 1'b1, 32'hCAFEF00D);

        // Fetch that never gets an answer times out.
        new_inst(30'h00000400);
        run_txn(int'(MAX_WAIT) + 1, 1'b0, $urandom);

        // Acknowledge on the very cycle the timeout would fire completes normally.
        new_data(30'h00000500, 32'h0, 4'b0000);
        run_txn(int'(MAX_WAIT), 1'b0, 32'h600DDA7A);

        // Reset asserted in the second BUSY cycle clears everything without a clock edge.
        new_inst(30'h00000600);
        new_data(30'h00000700, 32'h55556666, 4'b1100);
        @(negedge clk);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        model_reset();
        check_all_clear("async_rst");
        @(negedge clk);
        check_all_clear("in_rst");
        rst_b = 1'b1;
        run_txn(2, 1'b0, $urandom);
        run_txn(0, 1'b0, $urandom);

        // Randomized traffic.
        for (int r = 0; r < 80; r++) begin
            if (!pend_i && $urandom_range(1, 0) == 1) new_inst(ADDR_W'($urandom));
            if (!pend_d && $urandom_range(1, 0) == 1) new_data(ADDR_W'($urandom), $urandom, 4'($urandom));
            if (!pend_i && !pend_d) begin
                @(negedge clk);
                check("quiet_busy", 64'(busy), 64'(1'b0));
                check("quiet_m_req", 64'(m_req), 64'(1'b0));
                continue;
            end
            sel = int'($urandom_range(9, 0));
            if (sel < 7) w = int'($urandom_range(4, 0));
            else if (sel == 7) w = int'(MAX_WAIT);
            else w = int'(MAX_WAIT) + 1;
            err = ($urandom_range(5, 0) == 0);
            run_txn(w, err, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
